// File: rtl/frontend_pipe_ctrl.sv
// Instruction front-end sequencing: fetch tracking, F2/D1 stall/flush, post-redirect discard, halt handshake.
// Build macro FE_CTRL_DISCARD_CNT_EN adds the saturating Discarded counter port.
module frontend_pipe_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 2,
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          IMem_ReqAccept,
  input  logic          IMem_RespValid,
  input  logic          D2_Stall,
  input  logic          Redirect,
  input  logic          Halt_Req,
  output logic          F1_ReqValid,
  output logic          F2_Stall,
  output logic          F2_Issued,
  output logic          D1_Stall,
  output logic          D1_Flush,
  output logic          Halt_Ack,
`ifdef FE_CTRL_DISCARD_CNT_EN
  output logic [CW-1:0] Inflight,
  output logic [15:0]   Discarded
`else
  output logic [CW-1:0] Inflight
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    QUIESCE = 2'd2,
    HALTED  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          halt_ack_q, halt_ack_d;

  logic          resp_ok;
  logic          disc_pend;
  logic          accept;
  logic          consume;
  logic          discarding;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign resp_ok    = IMem_RespValid & (inflight_q != '0);
  assign disc_pend  = (discard_q != '0);
  assign accept     = IMem_ReqAccept & F1_ReqValid;
  assign consume    = resp_ok & ~F2_Stall;
  assign discarding = consume & (disc_pend | Redirect);

  // Counter next-state; a redirect reload overrides any same-cycle decrement.
  always_comb begin
    inflight_d = inflight_q + CW'(accept) - CW'(consume);
    discard_d  = discard_q;
    if (Redirect) begin
      discard_d = inflight_q - CW'(consume);
    end else if (discarding) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (Halt_Req) begin
          state_d = QUIESCE;
        end else if (Redirect && (discard_d != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (Halt_Req) begin
          state_d = QUIESCE;
        end else if (discard_d == '0) begin
          state_d = RUN;
        end
      end
      QUIESCE: begin
        if (!Halt_Req) begin
          state_d = (discard_d == '0) ? RUN : DRAIN;
        end else if (inflight_d == '0) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (!Halt_Req) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    D1_Flush    = Redirect | reset;
    D1_Stall    = D2_Stall & ~Redirect;
    F2_Stall    = D1_Stall & ~disc_pend;
    F2_Issued   = resp_ok & ~disc_pend & ~Redirect & ~reset;
    F1_ReqValid = (state_q == RUN) & ~Redirect & ~D1_Stall &
                  (inflight_q < CW'(MAX_INFLIGHT)) & ~reset;
    halt_ack_d  = (state_q == HALTED) & Halt_Req;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
      discard_q  <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      halt_ack_q <= halt_ack_d;
    end
  end

  assign Inflight = inflight_q;
  assign Halt_Ack = halt_ack_q;

`ifdef FE_CTRL_DISCARD_CNT_EN
  logic [15:0] discarded_q;

  // Saturating count of consumed-and-dropped responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      discarded_q <= 16'h0000;
    end else if (discarding && (discarded_q != 16'hFFFF)) begin
      discarded_q <= discarded_q + 16'd1;
    end
  end

  assign Discarded = discarded_q;
`endif

endmodule

// File: doc/frontend_pipe_ctrl.md
# frontend_pipe_ctrl

Sequencing controller for the instruction front end (F1 request, F2 response, D1 pipeline register). It tracks outstanding instruction-memory fetches and drives the F2 and D1 stall/flush controls. After a redirect, it discards fetch responses that were already in flight. It also provides a halt/quiesce handshake so cache maintenance can run with the front end idle.

## Interface
- MAX_INFLIGHT, 2, maximum accepted-but-unconsumed fetches; legal range 1..7; CW = clog2(MAX_INFLIGHT+1)
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- IMem_ReqAccept  in  1  memory accepted F1's request this cycle; ignored when F1_ReqValid=0
- IMem_RespValid  in  1  fetch response present at F2 this cycle; memory holds it while F2_Stall=1
- D2_Stall  in  1  D2 cannot accept D1's contents
- Redirect  in  1  branch/exception redirect from a later stage (single-cycle pulse)
- Halt_Req  in  1  level request to idle the front end
- F1_ReqValid  out  1  F1 may present a fetch request
- F2_Stall  out  1  hold memory response at F2
- F2_Issued  out  1  valid, non-discarded instruction presented to D1 (feeds D1's F2_Issued)
- D1_Stall  out  1  hold D1 register
- D1_Flush  out  1  flush D1 register
- Halt_Ack  out  1  front end idle, registered
- Inflight  out  CW  outstanding fetch count, registered
- Discarded  out  16  saturating discard count (FE_CTRL_DISCARD_CNT_EN only)

## Operation
- State registers:
  - FSM with states RUN, DRAIN, QUIESCE, HALTED.
  - inflight[CW-1:0] and discard[CW-1:0].
- consume = IMem_RespValid & ~F2_Stall.
- Inflight counter:
  - inflight_next = inflight + (IMem_ReqAccept & F1_ReqValid) - consume.
  - Simultaneous accept and consume leaves the count unchanged.
  - The count never exceeds MAX_INFLIGHT and never underflows.
  - A response with inflight=0 is a protocol error: ignored, not consumed, F2_Issued=0.
- Discard logic:
  - A response is discarded when it arrives with discard>0 or Redirect=1.
  - Discarded responses are always consumed, even if D2_Stall=1, and discard decrements.
- Redirect:
  - discard loads inflight - consume; this overrides any decrement in the same cycle.
  - The state moves RUN→DRAIN if the loaded value is >0.
  - A redirect in DRAIN reloads discard.
  - A redirect in QUIESCE or HALTED loads discard but keeps the state.
- Combinational outputs:
  - D1_Flush = Redirect | reset.
  - D1_Stall = D2_Stall & ~Redirect.
  - F2_Stall = D1_Stall & (discard==0).
  - F2_Issued = IMem_RespValid & (inflight≠0) & (discard==0) & ~Redirect & ~reset.
  - F1_ReqValid = (state==RUN) & ~Redirect & ~D1_Stall & (inflight<MAX_INFLIGHT) & ~reset.
- State transitions:
  - RUN→QUIESCE on Halt_Req (higher priority than →DRAIN).
  - DRAIN→RUN when discard_next==0.
  - DRAIN→QUIESCE on Halt_Req; discarding continues.
  - QUIESCE: no issue; responses pass or discard per the rules above. →HALTED when inflight_next==0.
  - HALTED: Halt_Ack=1. →RUN when Halt_Req=0.
  - Halt_Req dropped in QUIESCE: →RUN if discard_next==0, else →DRAIN.

## Timing
- Reset values:
  - state RUN; inflight, discard and Discarded 0; Halt_Ack 0.
  - During the reset cycle: F1_ReqValid=0, F2_Issued=0, D1_Flush=1.
- First request: F1_ReqValid=1 the cycle after reset deasserts, when D2_Stall=0.
- Stall/flush outputs are same-cycle combinational from inputs. Inflight reflects the previous edge.
- Halt_Ack rises the cycle after inflight reaches 0 in QUIESCE. It falls the cycle after Halt_Req falls.
- Redirect never causes a stall cycle. Refetch issues in the first cycle with state==RUN after the pulse.
- Mid-operation reset discards all counts. The memory side is reset concurrently.

## Configuration
- FE_CTRL_DISCARD_CNT_EN defined:
  - Discarded increments by 1 per discarded consumed response.
  - It saturates at 16'hFFFF and clears on reset.
- Undefined: the Discarded port and its counter are absent.
- All other behaviour is identical in both builds.

## Test plan
- Streaming: accept every cycle, responses 1 cycle later, D2_Stall=0 → Inflight steady at 1, F2_Issued=1 every cycle, F1_ReqValid never drops.
- Backpressure: 2 in flight, D2_Stall=1 for 4 cycles → F2_Stall=D1_Stall=1, F1_ReqValid=0, Inflight holds 2; release → two issues on consecutive cycles.
- Redirect with 2 in flight plus a response the same cycle → D1_Flush=1, discard=1, DRAIN; next response discarded even under D2_Stall; RUN next cycle; F1_ReqValid=1.
- Redirect in DRAIN with discard=1 and 1 new accept pending → discard reloaded with the current inflight count; no response leaks as F2_Issued.
- Halt_Req with 2 in flight → no new requests; both responses issue; Halt_Ack=1 one cycle after Inflight=0; drop Halt_Req → RUN, F1_ReqValid=1 the following cycle.
- Reset asserted in DRAIN with discard=2 → next cycle inflight=0, discard=0, RUN; Discarded (macro build) =0.
